// File: rtl/mvm_pkg.sv
// Shared types for the matrix-vector multiplier scheduler: FSM state encoding and
// the fixed 4x4 operand geometry.
package mvm_pkg;

    localparam int MVM_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mvm_sched_state_t;

endpackage

// File: rtl/mvm_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after the
// pointer, wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(ptr_i) + k) % N_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mvm_scheduler.sv
// Time-shares a single 4x4 matrix-vector multiplier between N_REQ requesters with
// round-robin arbitration, one operation in flight, and a watchdog on the multiplier.
module mvm_scheduler
    import mvm_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*16*WIDTH-1:0]     req_m,
    input  logic [N_REQ*4*WIDTH-1:0]      req_v,
    output logic [N_REQ-1:0]              resp_valid,
    input  logic [N_REQ-1:0]              resp_ready,
    output logic [4*WIDTH-1:0]            resp_v,
    output logic                          resp_err,
    output logic                          mvm_start,
    output logic [16*WIDTH-1:0]           mvm_m1,
    output logic [4*WIDTH-1:0]            mvm_v1,
    input  logic                          mvm_busy,
    input  logic                          mvm_done,
    input  logic [4*WIDTH-1:0]            mvm_v_out
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = MVM_ROWS * MVM_ROWS * WIDTH;
    localparam int VW = MVM_ROWS * WIDTH;

    typedef logic signed [MVM_ROWS-1:0][MVM_ROWS-1:0][WIDTH-1:0] mat4_t;
    typedef logic signed [MVM_ROWS-1:0][WIDTH-1:0]               vec4_t;

    mvm_sched_state_t state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    timer_q, timer_d;
    mat4_t            m1_q, m1_d;
    vec4_t            v1_q, v1_d;
    vec4_t            resp_v_q, resp_v_d;
    logic             resp_err_q, resp_err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        m1_d       = m1_q;
        v1_d       = v1_q;
        resp_v_d   = resp_v_q;
        resp_err_d = resp_err_q;
        req_ready  = '0;
        resp_valid = '0;
        mvm_start  = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so req_ready reads 0 while rst_n_in is held low.
                if (arb_any && rst_n_in) begin
                    req_ready = arb_gnt;
                    gnt_d     = arb_idx;
                    m1_d      = req_m[int'(arb_idx)*MW +: MW];
                    v1_d      = req_v[int'(arb_idx)*VW +: VW];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!mvm_busy) begin
                    mvm_start = 1'b1;
                    timer_d   = TW'(1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A done arriving on the timeout cycle still delivers the real result.
                if (mvm_done) begin
                    resp_v_d   = mvm_v_out;
                    resp_err_d = 1'b0;
                    state_d    = RESP;
                end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                    resp_v_d   = '0;
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) begin
                    ptr_d   = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            timer_q    <= '0;
            m1_q       <= '0;
            v1_q       <= '0;
            resp_v_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            m1_q       <= m1_d;
            v1_q       <= v1_d;
            resp_v_q   <= resp_v_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign mvm_m1   = m1_q;
    assign mvm_v1   = v1_q;
    assign resp_v   = resp_v_q;
    assign resp_err = resp_err_q;

endmodule
